// File: rtl/pkt_chk.sv
// Packet framing/length checker with per-packet modulo sum and one status report per packet.
// Optional STAT_CNT_EN builds saturating drop/good/bad counters; otherwise those ports read 0.
module pkt_chk #(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8,
  parameter int MIN_LEN = 4,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [DATA_W-1:0] din,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [DATA_W-1:0] pkt_sum,
  output logic              pkt_err,
  output logic [1:0]        err_type,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_SOP   = 2'd1;
  localparam logic [1:0] E_SHORT = 2'd2;
  localparam logic [1:0] E_LONG  = 2'd3;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] sum;
    logic [1:0]        err;
  } rpt_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [DATA_W-1:0] sum, sum_n;
  logic              pend_vld, pend_vld_n;
  rpt_t              pend, pend_n;
  logic              a_vld, b_vld, out_vld;
  rpt_t              a_rpt, b_rpt, out_rpt;

  function automatic rpt_t mk_rpt(logic [LEN_W-1:0] l, logic [DATA_W-1:0] s, logic abort);
    rpt_t r;
    r.len = l;
    r.sum = s;
    r.err = abort ? E_SOP : ((l < MIN_L) ? E_SHORT : E_OK);
    return r;
  endfunction

  // a_rpt is the earlier report of this word, b_rpt only exists for abort + single-word packet
  always_comb begin
    state_n = state;
    len_n   = len;
    sum_n   = sum;
    a_vld   = 1'b0;
    b_vld   = 1'b0;
    a_rpt   = '0;
    b_rpt   = '0;
    if (din_vld) begin
      case (state)
        IDLE: begin
          if (din_sop) begin
            len_n = ONE_L;
            sum_n = din;
            if (din_eop) begin
              a_vld = 1'b1;
              a_rpt = mk_rpt(ONE_L, din, 1'b0);
            end else begin
              state_n = BUSY;
            end
          end
        end
        BUSY: begin
          if (din_sop) begin
            a_vld = 1'b1;
            a_rpt = mk_rpt(len, sum, 1'b1);
            len_n = ONE_L;
            sum_n = din;
            if (din_eop) begin
              b_vld   = 1'b1;
              b_rpt   = mk_rpt(ONE_L, din, 1'b0);
              state_n = IDLE;
            end
          end else if (len == MAX_L) begin
            a_vld   = 1'b1;
            a_rpt   = '{len: MAX_L, sum: sum, err: E_LONG};
            state_n = IDLE;
          end else begin
            len_n = len + ONE_L;
            sum_n = sum + din;
            if (din_eop) begin
              a_vld   = 1'b1;
              a_rpt   = mk_rpt(len + ONE_L, sum + din, 1'b0);
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Reports leave in order pend, a, b; the slot holds at most one (pend set implies IDLE, so no b)
  always_comb begin
    out_vld    = 1'b0;
    out_rpt    = '0;
    pend_vld_n = 1'b0;
    pend_n     = '0;
    if (pend_vld) begin
      out_vld    = 1'b1;
      out_rpt    = pend;
      pend_vld_n = a_vld;
      pend_n     = a_rpt;
    end else if (a_vld) begin
      out_vld    = 1'b1;
      out_rpt    = a_rpt;
      pend_vld_n = b_vld;
      pend_n     = b_rpt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      sum      <= '0;
      pend_vld <= 1'b0;
      pend     <= '0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_sum  <= '0;
      pkt_err  <= 1'b0;
      err_type <= '0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      sum      <= sum_n;
      pend_vld <= pend_vld_n;
      pend     <= pend_n;
      pkt_done <= out_vld;
      if (out_vld) begin
        pkt_len  <= out_rpt.len;
        pkt_sum  <= out_rpt.sum;
        err_type <= out_rpt.err;
        pkt_err  <= (out_rpt.err != E_OK);
      end
    end
  end

`ifdef STAT_CNT_EN
  logic        drop;
  logic [15:0] drop_q, good_q, bad_q;

  // The word that trips TOO_LONG is discarded too, so it counts as an orphan
  assign drop = din_vld && !din_sop && ((state == IDLE) || (len == MAX_L));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (drop && drop_q != 16'hFFFF)                  drop_q <= drop_q + 16'd1;
      if (pkt_done && !pkt_err && good_q != 16'hFFFF)  good_q <= good_q + 16'd1;
      if (pkt_done && pkt_err && bad_q != 16'hFFFF)    bad_q  <= bad_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
  assign pkt_cnt  = good_q;
  assign err_cnt  = bad_q;
`else
  assign drop_cnt = '0;
  assign pkt_cnt  = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_pkt_chk.sv
// Scoreboard bench for pkt_chk: a queue-based packet model predicts reports, a monitor pops them.
module tb_pkt_chk;
  localparam int MINL = 4;
  localparam int MAXL = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [15:0] din = '0;
  logic        pkt_done, pkt_err;
  logic [7:0]  pkt_len;
  logic [15:0] pkt_sum, drop_cnt, pkt_cnt, err_cnt;
  logic [1:0]  err_type;

  pkt_chk #(.DATA_W(16), .LEN_W(8), .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
    .din(din), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_sum(pkt_sum), .pkt_err(pkt_err),
    .err_type(err_type), .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int len; int sum; int err; } rpt_t;

  rpt_t exp_q[$];
  rpt_t mon_r;
  int   cur[$];
  bit   in_pkt;
  int   drop_m, good_m, bad_m;
  int   n_chk, n_err;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cexp(int v);
`ifdef STAT_CNT_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0 * v;
`endif
  endfunction

  // Reference model: a packet is just the list of its words
  task automatic close_pkt(bit abort);
    rpt_t r;
    int   s = 0;
    foreach (cur[i]) s += cur[i];
    r.len = cur.size();
    r.sum = s % 65536;
    r.err = abort ? 1 : ((r.len < MINL) ? 2 : 0);
    exp_q.push_back(r);
    if (r.err == 0) good_m++; else bad_m++;
    in_pkt = 0;
  endtask

  task automatic model(bit s, bit e, int d);
    if (s) begin
      if (in_pkt) close_pkt(1);
      cur.delete();
      cur.push_back(d);
      in_pkt = 1;
      if (e) close_pkt(0);
    end else if (!in_pkt) begin
      drop_m++;
    end else if (cur.size() == MAXL) begin
      rpt_t r;
      int   sm = 0;
      foreach (cur[i]) sm += cur[i];
      r.len = MAXL; r.sum = sm % 65536; r.err = 3;
      exp_q.push_back(r);
      bad_m++;
      drop_m++;
      in_pkt = 0;
    end else begin
      cur.push_back(d);
      if (e) close_pkt(0);
    end
  endtask

  task automatic send(bit v, bit s, bit e, logic [15:0] d);
    @(posedge clk); #1;
    din_vld = v; din_sop = s; din_eop = e; din = d;
    if (v) model(s, e, int'(d));
  endtask

  task automatic idle(int n);
    repeat (n) send(1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
  endtask

  task automatic chk_cnts(string tag);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), cexp(drop_m));
    chk({tag, "_pkt_cnt"},  int'(pkt_cnt),  cexp(good_m));
    chk({tag, "_err_cnt"},  int'(err_cnt),  cexp(bad_m));
  endtask

  always @(negedge clk) begin
    if (rst_n && pkt_done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got len=%0d sum=%0d err=%0d expected no report",
                 pkt_len, pkt_sum, err_type);
      end else begin
        mon_r = exp_q.pop_front();
        chk("pkt_len",  int'(pkt_len),  mon_r.len);
        chk("pkt_sum",  int'(pkt_sum),  mon_r.sum);
        chk("err_type", int'(err_type), mon_r.err);
        chk("pkt_err",  int'(pkt_err),  int'(mon_r.err != 0));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pkt_done", int'(pkt_done), 0);
    chk("rst_pkt_len",  int'(pkt_len),  0);
    chk("rst_pkt_sum",  int'(pkt_sum),  0);
    chk("rst_pkt_err",  int'(pkt_err),  0);
    chk("rst_err_type", int'(err_type), 0);
    chk_cnts("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 1; i <= 12; i++) send(1, i == 1, i == 12, 16'(i));
    idle(3);

    for (int i = 0; i < 100; i++) send(1, i == 0, i == 99, 16'(i));
    for (int i = 0; i < 3; i++) send(1, i == 0, i == 2, 16'd5);
    idle(3);

    for (int i = 0; i < 4; i++) send(1, i == 0, 0, 16'($urandom));
    send(1, 1, 1, 16'd7);
    idle(4);

    for (int i = 0; i < 256; i++) send(1, i == 0, 0, 16'(i * 300));
    idle(3);
    chk_cnts("long");

    send(1, 1, 0, 16'h000F);
    send(1, 0, 0, 16'h00F0);
    send(0, 0, 0, 16'h0F00);
    send(1, 0, 0, 16'hF001);
    send(1, 0, 1, 16'h8001);
    idle(3);

    for (int i = 0; i < 5; i++) send(1, i == 0, 0, 16'(i + 40));
    @(posedge clk); #1;
    rst_n = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    chk("q_before_rst", exp_q.size(), 0);
    exp_q.delete(); cur.delete(); in_pkt = 0;
    drop_m = 0; good_m = 0; bad_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(1, i == 0, i == 3, 16'(i + 1));
    idle(3);
    chk_cnts("after_rst");

    repeat (800) begin
      bit v = ($urandom % 4) != 0;
      send(v, ($urandom % 7) == 0, ($urandom % 6) == 0, 16'($urandom));
    end
    idle(5);
    chk_cnts("rand");
    chk("q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
